dual_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the MAR_2 pair and dual-port MEM_2.

---
 rtl/dual_fetch_unit.sv | 102 ++++++++++
 tb/tb_dual_fetch_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dual_fetch_unit.sv
// Instruction fetch stage: reads opcode (PC) and operand (PC+1) in parallel through
// the MAR pair, then holds the pair for the decoder under a valid/ready handshake.
module dual_fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PC_RESET   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mar_load_a,
    output logic                  mar_load_b,
    output logic [ADDR_WIDTH-1:0] mar_addr_a,
    output logic [ADDR_WIDTH-1:0] mar_addr_b,
    output logic                  mem_oe_a,
    output logic                  mem_oe_b,
    input  logic [DATA_WIDTH-1:0] mem_data_a,
    input  logic [DATA_WIDTH-1:0] mem_data_b,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    input  logic                  halt,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0] operand,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  busy
);

    typedef enum logic [1:0] {ISSUE, READ, VALID, HALTED} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0]   opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0]   operand_q, operand_d;
    logic                    valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ISSUE;
            pc_q       <= ADDR_WIDTH'(PC_RESET);
            fetch_pc_q <= '0;
            opcode_q   <= '0;
            operand_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fetch_pc_q <= fetch_pc_d;
            opcode_q   <= opcode_d;
            operand_q  <= operand_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fetch_pc_d = fetch_pc_q;
        opcode_d   = opcode_q;
        operand_d  = operand_q;
        case (state_q)
            ISSUE:  state_d = halt ? HALTED : READ;
            READ: begin
                state_d    = VALID;
                opcode_d   = mem_data_a;
                operand_d  = mem_data_b;
                fetch_pc_d = pc_q;
                pc_d       = pc_q + ADDR_WIDTH'(2);
            end
            VALID:  if (instr_ready) state_d = halt ? HALTED : ISSUE;
            HALTED: if (!halt) state_d = ISSUE;
            default: state_d = ISSUE;
        endcase
        // A redirect discards any in-flight capture; a halted unit only takes the new PC.
        if (jump_en) begin
            pc_d       = jump_addr;
            fetch_pc_d = fetch_pc_q;
            opcode_d   = opcode_q;
            operand_d  = operand_q;
            state_d    = (state_q == HALTED && halt) ? HALTED : ISSUE;
        end
        valid_d = (state_d == VALID);
    end

    // Strobes are gated by reset so nothing reaches the MARs while reset is held.
    always_comb begin
        mar_load_a = rst && (state_q == ISSUE) && !halt;
        mar_load_b = mar_load_a;
        mem_oe_a   = rst && (state_q == READ);
        mem_oe_b   = mem_oe_a;
    end

    assign mar_addr_a  = pc_q;
    assign mar_addr_b  = pc_q + ADDR_WIDTH'(1);
    assign instr_valid = valid_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign fetch_pc    = fetch_pc_q;
    assign busy        = (state_q == ISSUE) || (state_q == READ);

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Bench for dual_fetch_unit: directed scenarios then randomized traffic, all checked
// against a transaction-level model of which address must be delivered next.
module tb_dual_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       mar_load_a, mar_load_b, mem_oe_a, mem_oe_b;
    logic [3:0] mar_addr_a, mar_addr_b;
    logic [7:0] mem_data_a, mem_data_b;
    logic       jump_en;
    logic [3:0] jump_addr;
    logic       halt;
    logic       instr_valid, instr_ready;
    logic [7:0] opcode, operand;
    logic [3:0] fetch_pc;
    logic       busy;

    logic [7:0] mem [16];
    logic [3:0] mar_a_q, mar_b_q;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    logic [3:0] exp_next = '0;

    always #5 clk = ~clk;

    dual_fetch_unit #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .PC_RESET(0)) dut (
        .clk(clk), .rst(rst),
        .mar_load_a(mar_load_a), .mar_load_b(mar_load_b),
        .mar_addr_a(mar_addr_a), .mar_addr_b(mar_addr_b),
        .mem_oe_a(mem_oe_a), .mem_oe_b(mem_oe_b),
        .mem_data_a(mem_data_a), .mem_data_b(mem_data_b),
        .jump_en(jump_en), .jump_addr(jump_addr), .halt(halt),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .operand(operand), .fetch_pc(fetch_pc), .busy(busy)
    );

    // External MAR pair feeding a combinational dual-port memory.
    always @(posedge clk) begin
        if (mar_load_a) mar_a_q <= mar_addr_a;
        if (mar_load_b) mar_b_q <= mar_addr_b;
    end
    assign mem_data_a = mem[mar_a_q];
    assign mem_data_b = mem[mar_b_q];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: advance the delivery model from pre-edge inputs, then check invariants.
    task automatic tick();
        logic       p_rst, p_v, p_r, p_j;
        logic [3:0] p_ja, p_fpc, a1;
        p_rst = rst; p_v = instr_valid; p_r = instr_ready;
        p_j = jump_en; p_ja = jump_addr; p_fpc = fetch_pc;
        @(posedge clk);
        #1;
        if (!p_rst) exp_next = 4'd0;
        else if (p_j) exp_next = p_ja;
        else if (p_v === 1'b1 && p_r) exp_next = p_fpc + 4'd2;
        if (p_rst && p_v === 1'b1 && p_r) hs_count++;
        if (!p_rst || p_j) chk("valid_drop", 32'(instr_valid), 32'd0);
        if (instr_valid === 1'b1) begin
            chk("deliv_pc", 32'(fetch_pc), 32'(exp_next));
            chk("deliv_opcode", 32'(opcode), 32'(mem[fetch_pc]));
            a1 = fetch_pc + 4'd1;
            chk("deliv_operand", 32'(operand), 32'(mem[a1]));
        end
        if (mar_load_a === 1'b1) begin
            a1 = mar_addr_a + 4'd1;
            chk("mar_b_addr", 32'(mar_addr_b), 32'(a1));
            chk("mar_b_load", 32'(mar_load_b), 32'd1);
        end
    endtask

    initial begin
        int hs0;
        rst = 1'b0; halt = 1'b0; jump_en = 1'b0; jump_addr = '0; instr_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        mem[2] = 8'hAA; mem[3] = 8'h55; mem[15] = 8'hC3; mem[0] = 8'h3C;

        // T1 reset held for three edges
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_valid", 32'(instr_valid), 32'd0);
            chk("rst_opcode", 32'(opcode), 32'd0);
            chk("rst_load", 32'(mar_load_a), 32'd0);
            chk("rst_oe", 32'(mem_oe_a), 32'd0);
        end
        rst = 1'b1; #1;
        chk("rel_load_a", 32'(mar_load_a), 32'd1);
        chk("rel_load_b", 32'(mar_load_b), 32'd1);
        chk("rel_addr_a", 32'(mar_addr_a), 32'd0);
        chk("rel_addr_b", 32'(mar_addr_b), 32'd1);

        // T2 jump to 2 then parallel fetch
        jump_en = 1'b1; jump_addr = 4'd2;
        tick(); jump_en = 1'b0;
        chk("t2_addr", 32'(mar_addr_a), 32'd2);
        tick(); chk("t2_lat1", 32'(instr_valid), 32'd0);
        chk("t2_oe", 32'(mem_oe_a & mem_oe_b), 32'd1);
        tick(); chk("t2_lat2", 32'(instr_valid), 32'd1);
        chk("t2_opcode", 32'(opcode), 32'hAA);
        chk("t2_operand", 32'(operand), 32'h55);
        chk("t2_pc", 32'(fetch_pc), 32'd2);

        // T3 backpressure
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_hold_v", 32'(instr_valid), 32'd1);
            chk("t3_hold_op", 32'(opcode), 32'hAA);
            chk("t3_hold_opnd", 32'(operand), 32'h55);
        end
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        chk("t3_next_addr", 32'(mar_addr_a), 32'd4);
        tick(); tick();
        chk("t3_next_pc", 32'(fetch_pc), 32'd4);

        // T4 wrap-around
        jump_en = 1'b1; jump_addr = 4'd15;
        tick(); jump_en = 1'b0;
        chk("t4_addr_a", 32'(mar_addr_a), 32'd15);
        chk("t4_addr_b", 32'(mar_addr_b), 32'd0);
        tick(); tick();
        chk("t4_opcode", 32'(opcode), 32'hC3);
        chk("t4_operand", 32'(operand), 32'h3C);
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        chk("t4_wrap_addr", 32'(mar_addr_a), 32'd1);
        tick(); tick();
        chk("t4_wrap_pc", 32'(fetch_pc), 32'd1);

        // T5 jump while in READ
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        tick(); chk("t5_in_read", 32'(mem_oe_a), 32'd1);
        jump_en = 1'b1; jump_addr = 4'd8;
        tick(); jump_en = 1'b0;
        tick(); chk("t5_no_old", 32'(instr_valid), 32'd0);
        tick(); chk("t5_pc", 32'(fetch_pc), 32'd8);
        chk("t5_valid", 32'(instr_valid), 32'd1);

        // T6 halt in VALID, then resume
        halt = 1'b1;
        tick(); chk("t6_hold", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t6_halt_load", 32'(mar_load_a), 32'd0);
            chk("t6_halt_valid", 32'(instr_valid), 32'd0);
            chk("t6_halt_busy", 32'(busy), 32'd0);
            tick();
        end
        halt = 1'b0;
        tick(); chk("t6_resume_load", 32'(mar_load_a), 32'd1);
        chk("t6_resume_addr", 32'(mar_addr_a), 32'd10);
        tick(); halt = 1'b1;
        tick(); chk("t6_inflight", 32'(instr_valid), 32'd1);
        chk("t6_inflight_pc", 32'(fetch_pc), 32'd10);
        instr_ready = 1'b1; tick(); instr_ready = 1'b0;
        jump_en = 1'b1; jump_addr = 4'd5;
        tick(); jump_en = 1'b0;
        chk("t6_jump_halted", 32'(busy), 32'd0);
        halt = 1'b0;
        tick(); chk("t6_jump_addr", 32'(mar_addr_a), 32'd5);

        // Throughput with ready tied high: one delivery every three cycles
        instr_ready = 1'b1;
        hs0 = hs_count;
        for (int i = 0; i < 30; i++) tick();
        chk("throughput", 32'(hs_count - hs0), 32'd10);

        // Randomized traffic
        hs0 = hs_count;
        for (int i = 0; i < 600; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            halt        = ($urandom_range(0, 9) == 0);
            jump_en     = ($urandom_range(0, 11) == 0);
            jump_addr   = 4'($urandom);
            tick();
        end
        jump_en = 1'b0; halt = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("rand_progress", 32'(hs_count > hs0 + 20), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
